// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scancode to ASCII translator with modifier tracking and a show-ahead character FIFO.
// Upstream handshake: sc_data is valid while sc_ready=1; sc_rd is a one-cycle pop and the code is taken on that edge.
module ps2_scancode_decoder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sc_ready,
  input  logic [7:0] sc_data,
  output logic       sc_rd,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       chr_ready,
  input  logic       clr_of,
  output logic       overflow
);

  typedef enum logic [1:0] {IDLE, POP, DECODE, WAIT} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t state, state_nxt;
  logic [7:0] code_q;
  logic brk, ext, shift_l, shift_r, ctrl, caps;
  logic shift;

  logic [7:0] map_lo, map_hi;
  logic       is_letter, mapped;
  logic       push_req;
  logic [7:0] push_char;

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic full, empty, do_rd, push_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sc_rd     = 1'b0;
    case (state)
      IDLE:    if (sc_ready) state_nxt = POP;
      POP:     begin sc_rd = 1'b1; state_nxt = DECODE; end
      DECODE:  state_nxt = WAIT;
      WAIT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) code_q <= 8'h00;
    else if (state == POP) code_q <= sc_data;
  end

  // Unshifted/shifted characters for non-extended set-2 codes.
  always_comb begin
    map_lo    = 8'h00;
    map_hi    = 8'h00;
    is_letter = 1'b0;
    mapped    = 1'b1;
    case (code_q)
      8'h1C: begin map_lo = 8'h61; is_letter = 1'b1; end
      8'h32: begin map_lo = 8'h62; is_letter = 1'b1; end
      8'h21: begin map_lo = 8'h63; is_letter = 1'b1; end
      8'h23: begin map_lo = 8'h64; is_letter = 1'b1; end
      8'h24: begin map_lo = 8'h65; is_letter = 1'b1; end
      8'h2B: begin map_lo = 8'h66; is_letter = 1'b1; end
      8'h34: begin map_lo = 8'h67; is_letter = 1'b1; end
      8'h33: begin map_lo = 8'h68; is_letter = 1'b1; end
      8'h43: begin map_lo = 8'h69; is_letter = 1'b1; end
      8'h3B: begin map_lo = 8'h6A; is_letter = 1'b1; end
      8'h42: begin map_lo = 8'h6B; is_letter = 1'b1; end
      8'h4B: begin map_lo = 8'h6C; is_letter = 1'b1; end
      8'h3A: begin map_lo = 8'h6D; is_letter = 1'b1; end
      8'h31: begin map_lo = 8'h6E; is_letter = 1'b1; end
      8'h44: begin map_lo = 8'h6F; is_letter = 1'b1; end
      8'h4D: begin map_lo = 8'h70; is_letter = 1'b1; end
      8'h15: begin map_lo = 8'h71; is_letter = 1'b1; end
      8'h2D: begin map_lo = 8'h72; is_letter = 1'b1; end
      8'h1B: begin map_lo = 8'h73; is_letter = 1'b1; end
      8'h2C: begin map_lo = 8'h74; is_letter = 1'b1; end
      8'h3C: begin map_lo = 8'h75; is_letter = 1'b1; end
      8'h2A: begin map_lo = 8'h76; is_letter = 1'b1; end
      8'h1D: begin map_lo = 8'h77; is_letter = 1'b1; end
      8'h22: begin map_lo = 8'h78; is_letter = 1'b1; end
      8'h35: begin map_lo = 8'h79; is_letter = 1'b1; end
      8'h1A: begin map_lo = 8'h7A; is_letter = 1'b1; end
      8'h16: begin map_lo = 8'h31; map_hi = 8'h21; end
      8'h1E: begin map_lo = 8'h32; map_hi = 8'h40; end
      8'h26: begin map_lo = 8'h33; map_hi = 8'h23; end
      8'h25: begin map_lo = 8'h34; map_hi = 8'h24; end
      8'h2E: begin map_lo = 8'h35; map_hi = 8'h25; end
      8'h36: begin map_lo = 8'h36; map_hi = 8'h5E; end
      8'h3D: begin map_lo = 8'h37; map_hi = 8'h26; end
      8'h3E: begin map_lo = 8'h38; map_hi = 8'h2A; end
      8'h46: begin map_lo = 8'h39; map_hi = 8'h28; end
      8'h45: begin map_lo = 8'h30; map_hi = 8'h29; end
      8'h0E: begin map_lo = 8'h60; map_hi = 8'h7E; end
      8'h4E: begin map_lo = 8'h2D; map_hi = 8'h5F; end
      8'h55: begin map_lo = 8'h3D; map_hi = 8'h2B; end
      8'h54: begin map_lo = 8'h5B; map_hi = 8'h7B; end
      8'h5B: begin map_lo = 8'h5D; map_hi = 8'h7D; end
      8'h5D: begin map_lo = 8'h5C; map_hi = 8'h7C; end
      8'h4C: begin map_lo = 8'h3B; map_hi = 8'h3A; end
      8'h52: begin map_lo = 8'h27; map_hi = 8'h22; end
      8'h41: begin map_lo = 8'h2C; map_hi = 8'h3C; end
      8'h49: begin map_lo = 8'h2E; map_hi = 8'h3E; end
      8'h4A: begin map_lo = 8'h2F; map_hi = 8'h3F; end
      8'h29: begin map_lo = 8'h20; map_hi = 8'h20; end
      8'h5A: begin map_lo = 8'h0D; map_hi = 8'h0D; end
      8'h66: begin map_lo = 8'h08; map_hi = 8'h08; end
      8'h0D: begin map_lo = 8'h09; map_hi = 8'h09; end
      8'h76: begin map_lo = 8'h1B; map_hi = 8'h1B; end
      default: mapped = 1'b0;
    endcase
    if (is_letter) map_hi = map_lo & 8'hDF;
  end

  assign shift = shift_l | shift_r;

  always_comb begin
    push_req  = 1'b0;
    push_char = 8'h00;
    if (state == DECODE && !brk) begin
      case (code_q)
        8'hF0, 8'hE0, 8'h12, 8'h59, 8'h14, 8'h58: push_req = 1'b0;
        default: begin
          if (ext) begin
            case (code_q)
              8'h75: begin push_req = 1'b1; push_char = 8'h80; end
              8'h72: begin push_req = 1'b1; push_char = 8'h81; end
              8'h6B: begin push_req = 1'b1; push_char = 8'h82; end
              8'h74: begin push_req = 1'b1; push_char = 8'h83; end
              default: push_req = 1'b0;
            endcase
          end else if (mapped) begin
            push_req = 1'b1;
            if (is_letter && ctrl)  push_char = map_lo & 8'h1F;
            else if (is_letter)     push_char = (shift ^ caps) ? map_hi : map_lo;
            else                    push_char = shift ? map_hi : map_lo;
          end
        end
      endcase
    end
  end

  // Prefix flags accumulate; any other code consumes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk <= 1'b0; ext <= 1'b0; shift_l <= 1'b0;
      shift_r <= 1'b0; ctrl <= 1'b0; caps <= 1'b0;
    end else if (state == DECODE) begin
      if (code_q == 8'hF0) brk <= 1'b1;
      else if (code_q == 8'hE0) ext <= 1'b1;
      else begin
        case (code_q)
          8'h12: shift_l <= ~brk;
          8'h59: shift_r <= ~brk;
          8'h14: ctrl    <= ~brk;
          8'h58: if (!brk) caps <= ~caps;
          default: ;
        endcase
        brk <= 1'b0;
        ext <= 1'b0;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_rd   = rd && !empty;
  assign push_ok = push_req && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd)   rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push_req && full && !do_rd) overflow <= 1'b1;
      else if (clr_of)                overflow <= 1'b0;
    end
  end

  assign chr_ready = !empty;
  assign dout      = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: vector table of single keys plus hand-written modifier/FIFO/reset sequences.
module tb_ps2_scancode_decoder;

  logic       clk, rst, sc_ready, sc_rd, rd, chr_ready, clr_of, overflow;
  logic [7:0] sc_data, dout;

  int tests = 0;
  int fails = 0;
  int pop_cnt = 0;
  logic lat_n2, lat_n3;

  typedef struct {
    logic       shift;
    logic [7:0] code;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[14];
  logic [7:0] lc[17];

  ps2_scancode_decoder #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .sc_ready(sc_ready), .sc_data(sc_data), .sc_rd(sc_rd),
    .rd(rd), .dout(dout), .chr_ready(chr_ready), .clr_of(clr_of), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (sc_rd) pop_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers
  task automatic send_code(input logic [7:0] c, input logic rd_dec);
    bit seen;
    @(negedge clk);
    sc_ready = 1'b1;
    sc_data  = c;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (sc_rd) seen = 1'b1;
    end
    if (!seen) check("sc_rd_timeout", {31'd0, sc_rd}, 32'd1);
    @(negedge clk);
    sc_ready = 1'b0;
    sc_data  = 8'h00;
    rd       = rd_dec;
    lat_n2   = chr_ready;
    @(negedge clk);
    rd     = 1'b0;
    lat_n3 = chr_ready;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] c);
    send_code(c, 1'b0);
  endtask

  task automatic tap(input logic [7:0] c);
    send(c); send(8'hF0); send(c);
  endtask

  task automatic rd_pulse();
    @(negedge clk); rd = 1'b1;
    @(negedge clk); rd = 1'b0;
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr_of = 1'b1;
    @(negedge clk); clr_of = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 8'h1C, 8'h61};
    vecs[1]  = '{1'b1, 8'h1C, 8'h41};
    vecs[2]  = '{1'b0, 8'h16, 8'h31};
    vecs[3]  = '{1'b1, 8'h16, 8'h21};
    vecs[4]  = '{1'b0, 8'h29, 8'h20};
    vecs[5]  = '{1'b0, 8'h5A, 8'h0D};
    vecs[6]  = '{1'b0, 8'h66, 8'h08};
    vecs[7]  = '{1'b0, 8'h0D, 8'h09};
    vecs[8]  = '{1'b0, 8'h76, 8'h1B};
    vecs[9]  = '{1'b1, 8'h4A, 8'h3F};
    vecs[10] = '{1'b0, 8'h52, 8'h27};
    vecs[11] = '{1'b1, 8'h52, 8'h22};
    vecs[12] = '{1'b0, 8'h1A, 8'h7A};
    vecs[13] = '{1'b1, 8'h0E, 8'h7E};
    lc = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
           8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15};

    rst = 1'b1; sc_ready = 1'b0; sc_data = 8'h00; rd = 1'b0; clr_of = 1'b0;
    lat_n2 = 1'b0; lat_n3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sc_rd", {31'd0, sc_rd}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'h00);
    check("rst_chr_ready", {31'd0, chr_ready}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // single key press with latency
    send(8'h1C);
    check("lat_cycle1", {31'd0, lat_n2}, 32'd0);
    check("lat_cycle2", {31'd0, lat_n3}, 32'd1);
    send(8'hF0); send(8'h1C);
    check("t1_dout", {24'd0, dout}, 32'h61);
    check("t1_ready", {31'd0, chr_ready}, 32'd1);
    rd_pulse();
    check("t1_dout_empty", {24'd0, dout}, 32'h00);
    check("t1_ready_empty", {31'd0, chr_ready}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].shift) send(8'h12);
      tap(vecs[i].code);
      if (vecs[i].shift) begin send(8'hF0); send(8'h12); end
      check($sformatf("vec%0d_ready", i), {31'd0, chr_ready}, 32'd1);
      check($sformatf("vec%0d_dout", i), {24'd0, dout}, {24'd0, vecs[i].exp});
      rd_pulse();
      check($sformatf("vec%0d_drained", i), {31'd0, chr_ready}, 32'd0);
    end

    // shift and caps interaction
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    check("t2_head0", {24'd0, dout}, 32'h41);
    rd_pulse();
    check("t2_head1", {24'd0, dout}, 32'h61);
    rd_pulse();
    check("t2_empty", {31'd0, chr_ready}, 32'd0);
    send(8'hF0); send(8'h1C);
    tap(8'h58);
    tap(8'h1C);
    check("t2_caps", {24'd0, dout}, 32'h41);
    rd_pulse();
    send(8'h12); tap(8'h1C); send(8'hF0); send(8'h12);
    check("t2_caps_shift", {24'd0, dout}, 32'h61);
    rd_pulse();
    tap(8'h58);

    // ctrl, extended arrows, extended break
    send(8'h14); send(8'h21);
    check("t3_ctrl_c", {24'd0, dout}, 32'h03);
    rd_pulse();
    send(8'hF0); send(8'h21); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'h75);
    check("t3_up", {24'd0, dout}, 32'h80);
    rd_pulse();
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t3_ext_brk", {31'd0, chr_ready}, 32'd0);
    send(8'hE0); send(8'h74);
    check("t3_right", {24'd0, dout}, 32'h83);
    rd_pulse();
    send(8'hE0); send(8'hF0); send(8'h74);

    // overflow on the 17th push
    for (int i = 0; i < 17; i++) send(lc[i]);
    check("t4_overflow", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_drain%0d", i), {24'd0, dout}, 32'h61 + i);
      rd_pulse();
    end
    check("t4_empty", {31'd0, chr_ready}, 32'd0);
    check("t4_of_sticky", {31'd0, overflow}, 32'd1);
    clr_pulse();
    check("t4_of_clr", {31'd0, overflow}, 32'd0);

    // full FIFO, read and push on the same edge
    for (int i = 0; i < 16; i++) send(lc[i]);
    send_code(8'h1C, 1'b1);
    check("t5_no_overflow", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5_drain%0d", i), {24'd0, dout}, (i < 15) ? 32'h62 + i : 32'h61);
      rd_pulse();
    end
    check("t5_empty", {31'd0, chr_ready}, 32'd0);
    rd_pulse();
    check("t5_rd_empty_ready", {31'd0, chr_ready}, 32'd0);
    check("t5_rd_empty_dout", {24'd0, dout}, 32'h00);
    check("t5_rd_empty_of", {31'd0, overflow}, 32'd0);

    // sc_ready held high: one pop per 4 cycles
    begin
      int p0;
      p0 = pop_cnt;
      @(negedge clk); sc_ready = 1'b1; sc_data = 8'h29;
      repeat (12) @(negedge clk);
      sc_ready = 1'b0; sc_data = 8'h00;
      #1;
      check("t7_pops", pop_cnt - p0, 32'd3);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("t7_space%0d", i), {24'd0, dout}, 32'h20);
        rd_pulse();
      end
      check("t7_empty", {31'd0, chr_ready}, 32'd0);
    end

    // reset during POP
    tap(8'h58);
    tap(8'h1C);
    check("t6_caps_before", {24'd0, dout}, 32'h41);
    begin
      bit seen;
      @(negedge clk); sc_ready = 1'b1; sc_data = 8'h1C;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        @(negedge clk);
        if (sc_rd) seen = 1'b1;
      end
      if (!seen) check("t6_pop_timeout", {31'd0, sc_rd}, 32'd1);
      rst = 1'b1;
      #1;
      check("t6_sc_rd_drop", {31'd0, sc_rd}, 32'd0);
      check("t6_fifo_empty", {31'd0, chr_ready}, 32'd0);
      check("t6_dout_zero", {24'd0, dout}, 32'h00);
      sc_ready = 1'b0; sc_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
    end
    tap(8'h1C);
    check("t6_after_rst", {24'd0, dout}, 32'h61);
    rd_pulse();
    check("t6_final_empty", {31'd0, chr_ready}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
